// File: rtl/alu_main_if.sv
// Operand/select/result bundle between the calculator front-end FSM and the accumulator ALU.
interface alu_main_if;
    localparam int unsigned DATA_W = 8;

    logic              on;
    logic [2:0]        in_sel;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
    logic [6:0]        out_sel;
    logic [DATA_W-1:0] final1;
    logic [DATA_W-1:0] final2;
    logic [DATA_W-1:0] out;
    logic [1:0]        currState;
    logic [1:0]        nextState;

    modport master (
        output on, in_sel, num1, num2, out_sel,
        input  final1, final2, out, currState, nextState
    );

    modport slave (
        input  on, in_sel, num1, num2, out_sel,
        output final1, final2, out, currState, nextState
    );
endinterface

// File: rtl/alu_main.sv
// 8-bit accumulator ALU: one-hot operand source and operation select, registered result
// and operands, 2-bit status state machine with its combinational next state exposed.
module alu_main (
    input logic       clk,
    input logic       rst,
    alu_main_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = DW + 1;

    localparam logic [2:0] SEL_PERSIST = 3'b001;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_CLEAR   = 3'b100;

    localparam logic [6:0] OP_MUL = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_ADD = 7'b0010000;
    localparam logic [6:0] OP_NOT = 7'b0001000;
    localparam logic [6:0] OP_XOR = 7'b0000100;
    localparam logic [6:0] OP_OR  = 7'b0000010;
    localparam logic [6:0] OP_AND = 7'b0000001;

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_CLEARED = 2'b01,
        ST_VALID   = 2'b10,
        ST_OVF     = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   out_q, out_d;
    logic [DW-1:0]   f1_q, f1_d;
    logic [DW-1:0]   f2_q, f2_d;
    logic [DW-1:0]   op_a, op_b, result;
    logic [PW-1:0]   product;
    logic [SW-1:0]   sum;
    logic            ovf;
    logic            compute_ok;

    // Datapath: persist feeds back the result registered before this edge.
    always_comb begin
        op_a       = (bus.in_sel == SEL_LOAD) ? bus.num1 : out_q;
        op_b       = bus.num2;
        product    = PW'(op_a) * PW'(op_b);
        sum        = SW'(op_a) + SW'(op_b);
        compute_ok = ((bus.in_sel == SEL_LOAD) || (bus.in_sel == SEL_PERSIST))
                     && $onehot(bus.out_sel);
        result     = '0;
        ovf        = 1'b0;
        case (bus.out_sel)
            OP_MUL: begin
                result = product[DW-1:0];
                ovf    = |product[PW-1:DW];
            end
            OP_SUB: begin
                result = op_a - op_b;
                ovf    = (op_a < op_b);
            end
            OP_ADD: begin
                result = sum[DW-1:0];
                ovf    = sum[DW];
            end
            OP_NOT:  result = ~op_a;
            OP_XOR:  result = op_a ^ op_b;
            OP_OR:   result = op_a | op_b;
            OP_AND:  result = op_a & op_b;
            default: result = '0;
        endcase
    end

    // Next-state rules in priority order: reset, off, clear, compute, hold.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        if (rst) begin
            state_d = ST_CLEARED;
            out_d   = '0;
            f1_d    = '0;
            f2_d    = '0;
        end else if (!bus.on) begin
            state_d = ST_OFF;
        end else if (bus.in_sel == SEL_CLEAR) begin
            state_d = ST_CLEARED;
            out_d   = '0;
            f1_d    = '0;
            f2_d    = '0;
        end else if (compute_ok) begin
            state_d = ovf ? ST_OVF : ST_VALID;
            out_d   = result;
            f1_d    = op_a;
            f2_d    = op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEARED;
            out_q   <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.final1    = f1_q;
    assign bus.final2    = f2_q;
    assign bus.currState = state_q;
    assign bus.nextState = state_d;
endmodule

// File: tb/tb_alu_main.sv
// Directed-vector bench for alu_main with hand-computed results and status states.
module tb_alu_main;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_main_if bus ();

    alu_main dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] PER = 3'b001;
    localparam logic [2:0] LD  = 3'b010;
    localparam logic [2:0] CLR = 3'b100;
    localparam logic [6:0] MUL = 7'b1000000;
    localparam logic [6:0] SUB = 7'b0100000;
    localparam logic [6:0] ADD = 7'b0010000;
    localparam logic [6:0] NOTOP = 7'b0001000;
    localparam logic [6:0] XOR = 7'b0000100;
    localparam logic [6:0] ORR = 7'b0000010;
    localparam logic [6:0] AND = 7'b0000001;
    localparam logic [1:0] S_OFF = 2'b00;
    localparam logic [1:0] S_CLR = 2'b01;
    localparam logic [1:0] S_VAL = 2'b10;
    localparam logic [1:0] S_OVF = 2'b11;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check nextState before the edge and registers after it.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [2:0] is, input logic [6:0] os,
                        input logic [7:0] n1, input logic [7:0] n2,
                        input logic [7:0] e_out, input logic [7:0] e_f1,
                        input logic [7:0] e_f2, input logic [1:0] e_st);
        @(negedge clk);
        rst         = r;
        bus.on      = en;
        bus.in_sel  = is;
        bus.out_sel = os;
        bus.num1    = n1;
        bus.num2    = n2;
        #1;
        chk({tag, "/nextState"}, {6'b0, bus.nextState}, {6'b0, e_st});
        @(posedge clk);
        #1;
        chk({tag, "/out"}, bus.out, e_out);
        chk({tag, "/final1"}, bus.final1, e_f1);
        chk({tag, "/final2"}, bus.final2, e_f2);
        chk({tag, "/currState"}, {6'b0, bus.currState}, {6'b0, e_st});
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b0;
        bus.on      = 1'b1;
        bus.in_sel  = LD;
        bus.out_sel = ADD;
        bus.num1    = 8'd0;
        bus.num2    = 8'd0;

        step("reset",      1'b1, 1'b1, LD,  ADD,   8'd5,   8'd5,   8'd0,   8'd0,   8'd0,   S_CLR);
        step("mul_1x2",    1'b0, 1'b1, LD,  MUL,   8'd1,   8'd2,   8'd2,   8'd1,   8'd2,   S_VAL);
        step("mul_3x2",    1'b0, 1'b1, LD,  MUL,   8'd3,   8'd2,   8'd6,   8'd3,   8'd2,   S_VAL);
        step("mul_ovf",    1'b0, 1'b1, LD,  MUL,   8'd87,  8'd26,  8'd214, 8'd87,  8'd26,  S_OVF);
        step("sub_193",    1'b0, 1'b1, LD,  SUB,   8'd193, 8'd134, 8'd59,  8'd193, 8'd134, S_VAL);
        step("sub_borrow", 1'b0, 1'b1, LD,  SUB,   8'd2,   8'd4,   8'd254, 8'd2,   8'd4,   S_OVF);
        step("sub_224",    1'b0, 1'b1, LD,  SUB,   8'd224, 8'd127, 8'd97,  8'd224, 8'd127, S_VAL);
        step("add_50",     1'b0, 1'b1, LD,  ADD,   8'd50,  8'd25,  8'd75,  8'd50,  8'd25,  S_VAL);
        step("add_9",      1'b0, 1'b1, LD,  ADD,   8'd9,   8'd10,  8'd19,  8'd9,   8'd10,  S_VAL);
        step("add_carry",  1'b0, 1'b1, LD,  ADD,   8'd200, 8'd100, 8'd44,  8'd200, 8'd100, S_OVF);
        step("not_50",     1'b0, 1'b1, LD,  NOTOP, 8'd50,  8'd25,  8'd205, 8'd50,  8'd25,  S_VAL);
        step("xor_50",     1'b0, 1'b1, LD,  XOR,   8'd50,  8'd25,  8'd43,  8'd50,  8'd25,  S_VAL);
        step("or_50",      1'b0, 1'b1, LD,  ORR,   8'd50,  8'd25,  8'd59,  8'd50,  8'd25,  S_VAL);
        step("and_50",     1'b0, 1'b1, LD,  AND,   8'd50,  8'd25,  8'd16,  8'd50,  8'd25,  S_VAL);
        step("not_129",    1'b0, 1'b1, LD,  NOTOP, 8'd129, 8'd3,   8'd126, 8'd129, 8'd3,   S_VAL);
        step("and_120",    1'b0, 1'b1, LD,  AND,   8'd120, 8'd1,   8'd0,   8'd120, 8'd1,   S_VAL);
        step("xor_8",      1'b0, 1'b1, LD,  XOR,   8'd8,   8'd10,  8'd2,   8'd8,   8'd10,  S_VAL);
        step("and_30",     1'b0, 1'b1, LD,  AND,   8'd30,  8'd30,  8'd30,  8'd30,  8'd30,  S_VAL);
        step("add_4",      1'b0, 1'b1, LD,  ADD,   8'd4,   8'd8,   8'd12,  8'd4,   8'd8,   S_VAL);
        step("persist",    1'b0, 1'b1, PER, ADD,   8'd99,  8'd8,   8'd20,  8'd12,  8'd8,   S_VAL);
        step("clear",      1'b0, 1'b1, CLR, ADD,   8'd77,  8'd66,  8'd0,   8'd0,   8'd0,   S_CLR);
        step("per_clr",    1'b0, 1'b1, PER, ADD,   8'd99,  8'd5,   8'd5,   8'd0,   8'd5,   S_VAL);
        step("off_1",      1'b0, 1'b0, LD,  MUL,   8'd9,   8'd9,   8'd5,   8'd0,   8'd5,   S_OFF);
        step("off_2",      1'b0, 1'b0, CLR, ADD,   8'd9,   8'd9,   8'd5,   8'd0,   8'd5,   S_OFF);
        step("per_off",    1'b0, 1'b1, PER, ADD,   8'd99,  8'd7,   8'd12,  8'd5,   8'd7,   S_VAL);
        step("mul_again",  1'b0, 1'b1, LD,  MUL,   8'd3,   8'd2,   8'd6,   8'd3,   8'd2,   S_VAL);
        step("bad_osel",   1'b0, 1'b1, LD,  7'b0000011, 8'd9, 8'd9, 8'd6,  8'd3,   8'd2,   S_VAL);
        step("bad_isel",   1'b0, 1'b1, 3'b011, ADD, 8'd9,  8'd9,   8'd6,   8'd3,   8'd2,   S_VAL);
        step("zero_osel",  1'b0, 1'b1, LD,  7'b0000000, 8'd9, 8'd9, 8'd6,  8'd3,   8'd2,   S_VAL);
        step("zero_isel",  1'b0, 1'b1, 3'b000, ADD, 8'd9,  8'd9,   8'd6,   8'd3,   8'd2,   S_VAL);
        step("ovf_again",  1'b0, 1'b1, LD,  ADD,   8'd200, 8'd100, 8'd44,  8'd200, 8'd100, S_OVF);
        step("bad_in_ovf", 1'b0, 1'b1, LD,  7'b1100000, 8'd1, 8'd1, 8'd44, 8'd200, 8'd100, S_OVF);
        step("rst_off",    1'b1, 1'b0, LD,  ADD,   8'd9,   8'd9,   8'd0,   8'd0,   8'd0,   S_CLR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_main.md
# alu_main

Top level of the 8-bit accumulator ALU. Each enabled clock it latches two operands (from the inputs, or from its own previous result), applies one of seven one-hot-selected operations, and registers the 8-bit result. A 2-bit status state machine reports whether the core is off, cleared, holding a valid result, or holding an overflowed result. It is the outermost block of the calculator datapath; the front-end FSM drives its selects.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge active.
- rst  in  1  synchronous reset, active high.
- on  in  1  enable; 0 = core off, all registers hold.
- in_sel  in  3  one-hot operand source: 3'b001 persist (A = current out), 3'b010 load (A = num1), 3'b100 clear.
- num1  in  8  operand A when loading.
- num2  in  8  operand B (load and persist).
- out_sel  in  7  one-hot operation: bit6 MUL, bit5 SUB, bit4 ADD, bit3 NOT, bit2 XOR, bit1 OR, bit0 AND.
- final1  out  8  registered operand A used for the current out.
- final2  out  8  registered operand B used for the current out.
- out  out  8  registered result (accumulator).
- currState  out  2  registered status state.
- nextState  out  2  combinational state to be entered at the next edge.

## Operation
- States: OFF=2'b00, CLEARED=2'b01, VALID=2'b10, OVF=2'b11.
- Per-edge priority: rst, then on=0, then in_sel=100, then a valid compute, then hold.
- rst=1: out, final1, final2 <= 0; currState <= CLEARED.
- on=0: out/final1/final2 hold; currState <= OFF.
- in_sel=100 with on=1: out, final1, final2 <= 0; currState <= CLEARED; out_sel ignored.
- Compute requires in_sel 010 or 001 and out_sel exactly one-hot.
  - A = num1 (load) or current out (persist); B = num2.
  - final1 <= A, final2 <= B, out <= result.
- Results, all 8-bit unsigned:
  - MUL = low byte of the 16-bit product; overflow if the high byte is nonzero.
  - SUB = (A-B) mod 256; overflow if A<B.
  - ADD = (A+B) mod 256; overflow on carry-out.
  - NOT = ~A, B ignored.
  - XOR, OR, AND are bitwise.
  - NOT and the logic ops never overflow.
- After a compute, currState <= OVF if overflow, otherwise VALID.
- Invalid in_sel (not one-hot, or 000) or invalid out_sel (zero or multi-hot) with on=1: all registers hold, state unchanged.
- nextState is the combinational evaluation of the same priority rules on the present inputs. currState equals the previous cycle's nextState.

## Timing
- Single clock domain; all state and outputs update on the rising edge of clk. The exception is nextState, which is combinational.
- Latency: one cycle. Inputs sampled at edge N appear on out/final1/final2/currState after edge N.
- Reset is synchronous: asserting rst between edges has no effect until the next edge. rst overrides on and every select in the same cycle.
- Persist uses the out value registered before the edge, so back-to-back persist cycles chain results with one op per cycle.
- Clear mid-sequence: the next persist after a clear uses A=0.
- Leaving OFF: the first edge with on=1 goes directly to whatever the selects dictate. Values held during OFF remain usable by persist.
- Hold cycles keep all outputs stable, with no glitches on the registered outputs.

## Test plan
- rst=1 for one edge -> out=0, final1=0, final2=0, currState=01. Then load 1 MUL 2 -> out=2, currState=10. Then load 3 MUL 2 -> out=6.
- Load 87 MUL 26 -> out=214 (0xD6), currState=11. Load 193 SUB 134 -> out=59, state 10. Load 2 SUB 4 -> out=254, state 11. Load 224 SUB 127 -> out=97.
- Load 50 ADD 25 -> 75. Load 9 ADD 10 -> 19. Load 200 ADD 100 -> out=44, state 11.
- Logic ops with A=50, B=25: NOT -> 205, XOR -> 43, OR -> 59, AND -> 16.
- Further logic cases: load 129 NOT 3 -> 126; 120 AND 1 -> 0; 8 XOR 10 -> 2; 30 AND 30 -> 30.
- Load 4 ADD 8 -> 12, then persist ADD num2=8 -> final1=12, out=20.
- in_sel=100 with out_sel=ADD -> out=0, state 01.
- on=0 for two edges -> outputs held, state 00. Then on=1 load 3 MUL 2 -> out=6.
- Invalid select hold: out_sel=0000011 -> all outputs hold. in_sel=011 -> all outputs hold.
- nextState check: on each cycle, nextState is compared against the following cycle's currState.
